instruction_loader: RTL and testbench
=====================================

# instruction_loader

Program loader that fills the MIPS instruction RAM before execution. It takes the byte stream delivered by the UART receiver, packs each four bytes into a 32-bit instruction word (first byte is the MSB) and writes the words to instruction memory at consecutive byte addresses 0, 4, 8, and so on. It holds the CPU pipeline in reset while loading. Loading stops after the HALT word has been written, or when memory is full.

## Interface
Parameters:
- `len`, 32, data and address width (matches fetch stage PC width).
- `depth`, 2048, instruction RAM depth in words.
- `HALT`, 32'hFFFFFFFF, terminating instruction word. It is written to memory before loading stops.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  one-cycle start pulse.
- `i_rx_done`  in  1  one-cycle strobe: `i_rx_data` holds a valid byte.
- `i_rx_data`  in  8  received byte.
- `out_wea`  out  1  instruction RAM write enable, one-cycle pulse.
- `out_addr`  out  len  RAM byte address, always a multiple of 4.
- `out_data`  out  len  instruction word to write.
- `out_word_count`  out  $clog2(depth)+1  number of words written in the current load.
- `out_busy`  out  1  high in LOAD and WRITE.
- `out_cpu_hold`  out  1  high while `out_busy` is high; drives pipeline reset.
- `out_done`  out  1  load finished.
- `out_overflow`  out  1  finished because memory was full, not because HALT arrived.

## Operation
- States: IDLE, LOAD, WRITE, DONE. Internal registers: shift word `word`, byte counter `byte_cnt` (2 bits), address, word count.
- **IDLE**
  - All outputs 0.
  - `i_rx_done` is ignored.
  - `i_start` moves to LOAD and clears `word`, `byte_cnt`, `out_addr` and `out_word_count`.
- **LOAD**
  - Each `i_rx_done` does `word <= {word[23:0], i_rx_data}` and `byte_cnt++`.
  - On the strobe with `byte_cnt==3`: latch `out_data <= {word[23:0], i_rx_data}`, set `byte_cnt <= 0`, go to WRITE.
- **WRITE** (exactly one cycle)
  - `out_wea=1`, with `out_addr` and `out_data` stable. `out_word_count++` at the end of the cycle.
  - Next state:
    - `out_data==HALT`: go to DONE.
    - Otherwise, if this was word index depth-1: go to DONE with `out_overflow=1`.
    - Otherwise: `out_addr += 4` and go to LOAD.
  - An `i_rx_done` in this cycle is accepted as byte 0 of the next word (`word` shifts, `byte_cnt=1`). No byte may be lost. After a transition to DONE that byte is discarded.
- **DONE**
  - `out_done=1`; `out_overflow` holds its value.
  - `i_rx_done` is ignored.
  - `i_start` restarts exactly as from IDLE and clears `out_done` and `out_overflow`.
- `i_start` is ignored in LOAD and WRITE.
- `out_busy` and `out_cpu_hold` are high exactly in LOAD and WRITE.
- Address arithmetic is unsigned `len`-bit. It cannot wrap, because overflow stops the load at 4*(depth-1).

## Timing
- Reset values: state IDLE; `out_wea`, `out_addr`, `out_data`, `out_word_count`, `out_busy`, `out_cpu_hold`, `out_done`, `out_overflow` all 0; partial word discarded.
- Reset in any state, including mid-word or during WRITE, takes effect at the next edge. No write is issued in the cycle after reset.
- Start latency: `out_busy` rises in the cycle after the `i_start` edge.
- Write latency: `out_wea` is high in the cycle immediately after the 4th `i_rx_done` of a word.
- `out_done` rises in the cycle after the final `out_wea` pulse. `out_busy` falls in that same cycle.
- Back-to-back `i_rx_done` strobes on consecutive cycles must be accepted with zero loss. Maximum throughput is one byte per clock.
- All outputs are registered.

## Test plan
- **Basic load.** Reset, `i_start`, bytes 00 00 00 01 FF FF FF FF.
  - Expect `out_wea` at addr 0 with data 0x00000001, then at addr 4 with data 0xFFFFFFFF.
  - Expect `out_done=1`, `out_word_count=2`, `out_overflow=0`, `out_cpu_hold` low after done.
- **Byte order.** Bytes 12 34 56 78 -> `out_data=0x12345678` at addr 0, one cycle after the 4th strobe.
- **Reset mid-word.** `i_start`, bytes AA BB, then `reset` -> no `out_wea`, all outputs 0.
  - Then `i_start`, bytes 00 00 00 05 -> write of 0x00000005 at addr 0.
- **Overflow.** Set `depth=4`. Send 4 non-HALT words, then 4 more bytes.
  - Expect writes at addr 0, 4, 8, 12, then `out_done=1`, `out_overflow=1`, `out_word_count=4`.
  - The extra bytes produce no `out_wea`.
- **Back-to-back strobes.** Strobe every cycle for 8 bytes 01..08, so byte 05 lands in the WRITE cycle.
  - Expect 0x01020304 at addr 0 and 0x05060708 at addr 4.
- **Start handling.** `i_start` during LOAD is ignored and the word count is unchanged.
  - `i_start` in DONE clears `out_done` and `out_overflow` and restarts at addr 0.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Bus between the UART byte source, the instruction loader and the
// instruction RAM / pipeline control.
//   i_start        : one-cycle start pulse
//   i_rx_done      : one-cycle strobe, i_rx_data holds a valid byte
//   i_rx_data      : received byte
//   out_wea        : instruction RAM write enable (one-cycle pulse)
//   out_addr       : RAM byte address (multiple of 4)
//   out_data       : instruction word to write
//   out_word_count : words written in the current load
//   out_busy       : loader is collecting or writing words
//   out_cpu_hold   : pipeline reset, follows out_busy
//   out_done       : load finished
//   out_overflow   : load finished because memory filled up
// The loader side uses the slave modport; the byte source / observer side
// uses the master modport.
interface instruction_loader_if #(
    parameter int len   = 32,
    parameter int depth = 2048
);
    localparam int CW = $clog2(depth) + 1;

    logic          i_start;
    logic          i_rx_done;
    logic [7:0]    i_rx_data;
    logic          out_wea;
    logic [len-1:0] out_addr;
    logic [len-1:0] out_data;
    logic [CW-1:0] out_word_count;
    logic          out_busy;
    logic          out_cpu_hold;
    logic          out_done;
    logic          out_overflow;

    modport master (
        output i_start, i_rx_done, i_rx_data,
        input  out_wea, out_addr, out_data, out_word_count,
        input  out_busy, out_cpu_hold, out_done, out_overflow
    );

    modport slave (
        input  i_start, i_rx_done, i_rx_data,
        output out_wea, out_addr, out_data, out_word_count,
        output out_busy, out_cpu_hold, out_done, out_overflow
    );
endinterface

// File: rtl/instruction_loader.sv
// Program loader for the MIPS instruction RAM. Packs the UART byte stream
// into big-endian words (first byte is the MSB) and writes them to byte
// addresses 0, 4, 8, ... while holding the CPU pipeline in reset. Loading
// stops after the HALT word has been written or after the last RAM word.
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high reset
//   bus   : instruction_loader_if.slave (start/byte inputs, RAM write and
//           status outputs, all outputs registered)
module instruction_loader #(
    parameter int             len   = 32,
    parameter int             depth = 2048,
    parameter logic [len-1:0] HALT  = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_loader_if.slave   bus
);
    localparam int             CW        = $clog2(depth) + 1;
    // Only the three most recent bytes are kept; the fourth byte is taken
    // straight from the input when the word completes.
    localparam int             SW        = len - 8;
    localparam logic [CW-1:0]  LAST_IDX  = CW'(depth - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [len-1:0] ADDR_STEP = len'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [SW-1:0]  word_r, word_nxt_s;
    logic [1:0]     byte_cnt_r, byte_cnt_nxt_s;
    logic [len-1:0] addr_r, addr_nxt_s;
    logic [len-1:0] data_r, data_nxt_s;
    logic [CW-1:0]  count_r, count_nxt_s;
    logic           overflow_r, overflow_nxt_s;
    logic           wea_r, wea_nxt_s;
    logic           busy_r, busy_nxt_s;
    logic           done_r, done_nxt_s;
    logic           is_halt_s;
    logic           is_last_s;

    assign is_halt_s = (data_r == HALT);
    assign is_last_s = (count_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.i_start) state_nxt_s = LOAD;
                else             state_nxt_s = IDLE;
            end
            LOAD: begin
                if (bus.i_rx_done && (byte_cnt_r == 2'd3)) state_nxt_s = WRITE;
                else                                        state_nxt_s = LOAD;
            end
            WRITE: begin
                if (is_halt_s || is_last_s) state_nxt_s = DONE;
                else                        state_nxt_s = LOAD;
            end
            DONE: begin
                if (bus.i_start) state_nxt_s = LOAD;
                else             state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath next values: byte packing, address/count advance, overflow flag.
    always_comb begin
        word_nxt_s     = word_r;
        byte_cnt_nxt_s = byte_cnt_r;
        addr_nxt_s     = addr_r;
        data_nxt_s     = data_r;
        count_nxt_s    = count_r;
        overflow_nxt_s = overflow_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    word_nxt_s     = '0;
                    byte_cnt_nxt_s = 2'd0;
                    addr_nxt_s     = '0;
                    count_nxt_s    = '0;
                    overflow_nxt_s = 1'b0;
                end else begin
                    overflow_nxt_s = overflow_r;
                end
            end
            LOAD: begin
                if (bus.i_rx_done) begin
                    word_nxt_s = {word_r[SW-9:0], bus.i_rx_data};
                    if (byte_cnt_r == 2'd3) begin
                        data_nxt_s     = {word_r, bus.i_rx_data};
                        byte_cnt_nxt_s = 2'd0;
                    end else begin
                        byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                    end
                end else begin
                    word_nxt_s = word_r;
                end
            end
            WRITE: begin
                count_nxt_s = count_r + CNT_ONE;
                if (is_halt_s) begin
                    overflow_nxt_s = 1'b0;
                end else if (is_last_s) begin
                    overflow_nxt_s = 1'b1;
                end else begin
                    addr_nxt_s = addr_r + ADDR_STEP;
                end
                // A byte arriving during the write is the first byte of the
                // next word; if the load ends here it is simply dropped
                // because a restart clears the packing registers.
                if (bus.i_rx_done) begin
                    word_nxt_s     = {word_r[SW-9:0], bus.i_rx_data};
                    byte_cnt_nxt_s = 2'd1;
                end else begin
                    byte_cnt_nxt_s = 2'd0;
                end
            end
            default: begin
                word_nxt_s = word_r;
            end
        endcase
    end

    // Output logic: status/strobe values for the coming state.
    always_comb begin
        wea_nxt_s  = 1'b0;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE:  busy_nxt_s = 1'b0;
            LOAD:  busy_nxt_s = 1'b1;
            WRITE: begin
                wea_nxt_s  = 1'b1;
                busy_nxt_s = 1'b1;
            end
            DONE:  done_nxt_s = 1'b1;
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r     <= '0;
            byte_cnt_r <= 2'd0;
            addr_r     <= '0;
            data_r     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            wea_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            word_r     <= word_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            addr_r     <= addr_nxt_s;
            data_r     <= data_nxt_s;
            count_r    <= count_nxt_s;
            overflow_r <= overflow_nxt_s;
            wea_r      <= wea_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign bus.out_wea        = wea_r;
    assign bus.out_addr       = addr_r;
    assign bus.out_data       = data_r;
    assign bus.out_word_count = count_r;
    assign bus.out_busy       = busy_r;
    assign bus.out_cpu_hold   = busy_r;
    assign bus.out_done       = done_r;
    assign bus.out_overflow   = overflow_r;
endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader. Two instances (depth 2048 and depth 4)
// receive the same byte stream; writes are captured on the falling edge and
// compared against a table of hand-computed expectations and against a
// word-level reference model for random streams.
module tb_instruction_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       tb_start;
    logic       tb_rx_done;
    logic [7:0] tb_rx_data;

    always #5 clk = ~clk;

    instruction_loader_if #(.len(32), .depth(2048)) bus_b ();
    instruction_loader_if #(.len(32), .depth(4))    bus_s ();

    assign bus_b.i_start   = tb_start;
    assign bus_b.i_rx_done = tb_rx_done;
    assign bus_b.i_rx_data = tb_rx_data;
    assign bus_s.i_start   = tb_start;
    assign bus_s.i_rx_done = tb_rx_done;
    assign bus_s.i_rx_data = tb_rx_data;

    instruction_loader #(.len(32), .depth(2048)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    instruction_loader #(.len(32), .depth(4))    dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] q_b[$];
    logic [63:0] q_s[$];
    logic [7:0]  stim_q[$];
    logic [31:0] mw_q[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_s[$];
    bit          m_done, m_ov, eb_done, es_done, es_ov;

    typedef struct packed {
        int           nb;
        int           gap;
        logic [255:0] stream;
        int           nw;
        logic [159:0] ew;
        bit           done_b;
        int           cnt_s;
        bit           done_s;
        bit           ov_s;
    } vec_t;

    vec_t vecs [6];

    // Write capture for both instances.
    always @(negedge clk) begin
        if (bus_b.out_wea === 1'b1) q_b.push_back({bus_b.out_addr, bus_b.out_data});
        if (bus_s.out_wea === 1'b1) q_s.push_back({bus_s.out_addr, bus_s.out_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        tb_rx_done = 1'b1;
        tb_rx_data = b;
        tick();
        tb_rx_done = 1'b0;
    endtask

    task automatic pulse_start();
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // gap < 0 selects a random 0..2 idle cycles after each byte.
    task automatic send_stim(input int gap);
        for (int i = 0; i < stim_q.size(); i++) begin
            strobe(stim_q[i]);
            repeat ((gap < 0) ? $urandom_range(0, 2) : gap) tick();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_b_wea"},   64'(bus_b.out_wea),        64'd0);
        chk({tag, "_b_addr"},  64'(bus_b.out_addr),       64'd0);
        chk({tag, "_b_data"},  64'(bus_b.out_data),       64'd0);
        chk({tag, "_b_count"}, 64'(bus_b.out_word_count), 64'd0);
        chk({tag, "_b_busy"},  64'(bus_b.out_busy),       64'd0);
        chk({tag, "_b_hold"},  64'(bus_b.out_cpu_hold),   64'd0);
        chk({tag, "_b_done"},  64'(bus_b.out_done),       64'd0);
        chk({tag, "_b_ovf"},   64'(bus_b.out_overflow),   64'd0);
        chk({tag, "_s_busy"},  64'(bus_s.out_busy),       64'd0);
        chk({tag, "_s_done"},  64'(bus_s.out_done),       64'd0);
        chk({tag, "_s_ovf"},   64'(bus_s.out_overflow),   64'd0);
    endtask

    // Reference: whole words in stream order, stop after HALT or after dep words.
    function automatic void model(input int dep);
        logic [31:0] x;
        mw_q.delete();
        m_done = 1'b0;
        m_ov   = 1'b0;
        for (int k = 0; (k + 3 < stim_q.size()) && !m_done; k += 4) begin
            x = {stim_q[k], stim_q[k+1], stim_q[k+2], stim_q[k+3]};
            mw_q.push_back(x);
            if (x == 32'hFFFFFFFF) begin
                m_done = 1'b1;
            end else if (mw_q.size() == dep) begin
                m_done = 1'b1;
                m_ov   = 1'b1;
            end
        end
    endfunction

    task automatic check_result(input string tag);
        chk({tag, "_b_nwrites"}, 64'(q_b.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < q_b.size(); i++)
            chk({tag, "_b_write"}, q_b[i], {32'(4 * i), exp_b[i]});
        chk({tag, "_b_count"}, 64'(bus_b.out_word_count), 64'(exp_b.size()));
        chk({tag, "_b_done"},  64'(bus_b.out_done),       64'(eb_done));
        chk({tag, "_b_ovf"},   64'(bus_b.out_overflow),   64'd0);
        chk({tag, "_b_busy"},  64'(bus_b.out_busy),       64'(!eb_done));
        chk({tag, "_b_hold"},  64'(bus_b.out_cpu_hold),   64'(!eb_done));
        chk({tag, "_s_nwrites"}, 64'(q_s.size()), 64'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < q_s.size(); i++)
            chk({tag, "_s_write"}, q_s[i], {32'(4 * i), exp_s[i]});
        chk({tag, "_s_count"}, 64'(bus_s.out_word_count), 64'(exp_s.size()));
        chk({tag, "_s_done"},  64'(bus_s.out_done),       64'(es_done));
        chk({tag, "_s_ovf"},   64'(bus_s.out_overflow),   64'(es_ov));
        chk({tag, "_s_hold"},  64'(bus_s.out_cpu_hold),   64'(!es_done));
        q_b.delete();
        q_s.delete();
    endtask

    initial begin
        vec_t        vec;
        logic [31:0] w;
        int          nwords;
        int          extra;

        reset      = 1'b1;
        tb_start   = 1'b0;
        tb_rx_done = 1'b0;
        tb_rx_data = 8'h00;

        vecs[0] = '{nb: 8, gap: 1, stream: {32'h00000001, 32'hFFFFFFFF, 192'h0}, nw: 2,
                    ew: {32'h00000001, 32'hFFFFFFFF, 96'h0}, done_b: 1'b1, cnt_s: 2, done_s: 1'b1, ov_s: 1'b0};
        vecs[1] = '{nb: 12, gap: 0, stream: {32'h01020304, 32'h05060708, 32'hFFFFFFFF, 160'h0}, nw: 3,
                    ew: {32'h01020304, 32'h05060708, 32'hFFFFFFFF, 64'h0}, done_b: 1'b1, cnt_s: 3, done_s: 1'b1, ov_s: 1'b0};
        vecs[2] = '{nb: 8, gap: 0, stream: {32'hFFFFFFFF, 32'h12345678, 192'h0}, nw: 1,
                    ew: {32'hFFFFFFFF, 128'h0}, done_b: 1'b1, cnt_s: 1, done_s: 1'b1, ov_s: 1'b0};
        vecs[3] = '{nb: 6, gap: 2, stream: {32'h11223344, 16'h5566, 208'h0}, nw: 1,
                    ew: {32'h11223344, 128'h0}, done_b: 1'b0, cnt_s: 1, done_s: 1'b0, ov_s: 1'b0};
        vecs[4] = '{nb: 20, gap: 0, stream: {32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 96'h0}, nw: 5,
                    ew: {32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, done_b: 1'b0, cnt_s: 4, done_s: 1'b1, ov_s: 1'b1};
        vecs[5] = '{nb: 16, gap: 1, stream: {32'h00000001, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, 128'h0}, nw: 4,
                    ew: {32'h00000001, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, 32'h0}, done_b: 1'b1, cnt_s: 4, done_s: 1'b1, ov_s: 1'b0};

        // Reset state, then bytes in IDLE must be ignored.
        do_reset();
        chk_zero("reset");
        q_b.delete();
        q_s.delete();
        repeat (4) strobe(8'h01);
        tick();
        chk_zero("idle_rx");
        chk("idle_rx_nwrites", 64'(q_b.size() + q_s.size()), 64'd0);

        // Table-driven loads.
        for (int v = 0; v < 6; v++) begin
            vec = vecs[v];
            do_reset();
            q_b.delete();
            q_s.delete();
            pulse_start();
            stim_q.delete();
            for (int i = 0; i < vec.nb; i++) stim_q.push_back(vec.stream[255 - 8 * i -: 8]);
            exp_b.delete();
            for (int i = 0; i < vec.nw; i++) exp_b.push_back(vec.ew[159 - 32 * i -: 32]);
            exp_s.delete();
            for (int i = 0; i < vec.cnt_s; i++) exp_s.push_back(vec.ew[159 - 32 * i -: 32]);
            eb_done = vec.done_b;
            es_done = vec.done_s;
            es_ov   = vec.ov_s;
            send_stim(vec.gap);
            repeat (4) tick();
            check_result($sformatf("vec%0d", v));
        end

        // Byte order and write latency: write strobe right after the 4th byte.
        do_reset();
        pulse_start();
        chk("start_busy", 64'(bus_b.out_busy), 64'd1);
        strobe(8'h12); tick();
        strobe(8'h34); tick();
        strobe(8'h56); tick();
        chk("pre_write_wea", 64'(bus_b.out_wea), 64'd0);
        strobe(8'h78);
        chk("lat_wea",  64'(bus_b.out_wea),  64'd1);
        chk("lat_addr", 64'(bus_b.out_addr), 64'd0);
        chk("lat_data", 64'(bus_b.out_data), 64'h12345678);
        tick();
        chk("post_write_wea",  64'(bus_b.out_wea),  64'd0);
        chk("post_write_addr", 64'(bus_b.out_addr), 64'd4);

        // Reset mid-word, then reload; then reset during a write cycle.
        do_reset();
        pulse_start();
        strobe(8'hAA);
        strobe(8'hBB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_b.delete();
        q_s.delete();
        chk_zero("rst_mid");
        repeat (3) tick();
        chk("rst_mid_nwrites", 64'(q_b.size()), 64'd0);
        pulse_start();
        strobe(8'h00); strobe(8'h00); strobe(8'h00); strobe(8'h05);
        tick();
        chk("reload_nwrites", 64'(q_b.size()), 64'd1);
        chk("reload_write", (q_b.size() > 0) ? q_b[0] : '1, {32'h0, 32'h00000005});
        strobe(8'h00); strobe(8'h00); strobe(8'h00); strobe(8'h07);
        chk("wr_before_rst_wea", 64'(bus_b.out_wea), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("rst_write");
        tick();
        chk("rst_write_wea_after", 64'(bus_b.out_wea), 64'd0);

        // Start pulses in LOAD and in WRITE are ignored.
        do_reset();
        q_b.delete();
        q_s.delete();
        pulse_start();
        strobe(8'h0A); tick(); strobe(8'h0B); tick(); strobe(8'h0C); tick(); strobe(8'h0D); tick();
        pulse_start();
        chk("start_in_load_count", 64'(bus_b.out_word_count), 64'd1);
        chk("start_in_load_addr",  64'(bus_b.out_addr),       64'd4);
        strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
        pulse_start();
        chk("start_in_write_count", 64'(bus_b.out_word_count), 64'd2);
        stim_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_stim(0);
        repeat (4) tick();
        exp_b   = '{32'h0A0B0C0D, 32'h11223344, 32'hFFFFFFFF};
        exp_s   = exp_b;
        eb_done = 1'b1;
        es_done = 1'b1;
        es_ov   = 1'b0;
        check_result("start_ign");

        // Overflow on the small instance, then restart from DONE.
        do_reset();
        q_b.delete();
        q_s.delete();
        pulse_start();
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(8'(i + 1));
        send_stim(0);
        repeat (4) tick();
        exp_b   = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
        exp_s   = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        eb_done = 1'b0;
        es_done = 1'b1;
        es_ov   = 1'b1;
        check_result("ovf");
        pulse_start();
        chk("restart_done",  64'(bus_s.out_done),       64'd0);
        chk("restart_ovf",   64'(bus_s.out_overflow),   64'd0);
        chk("restart_busy",  64'(bus_s.out_busy),       64'd1);
        chk("restart_count", 64'(bus_s.out_word_count), 64'd0);
        strobe(8'h00); strobe(8'h00); strobe(8'h00); strobe(8'h09);
        tick();
        chk("restart_nwrites", 64'(q_s.size()), 64'd1);
        chk("restart_write", (q_s.size() > 0) ? q_s[0] : '1, {32'h0, 32'h00000009});

        // Random streams against the word-level model.
        for (int it = 0; it < 25; it++) begin
            do_reset();
            q_b.delete();
            q_s.delete();
            pulse_start();
            stim_q.delete();
            nwords = $urandom_range(1, 7);
            for (int k = 0; k < nwords; k++) begin
                w = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                stim_q.push_back(w[31:24]);
                stim_q.push_back(w[23:16]);
                stim_q.push_back(w[15:8]);
                stim_q.push_back(w[7:0]);
            end
            extra = $urandom_range(0, 3);
            for (int k = 0; k < extra; k++) stim_q.push_back(8'($urandom));
            send_stim(-1);
            repeat (4) tick();
            model(2048);
            exp_b   = mw_q;
            eb_done = m_done;
            model(4);
            exp_s   = mw_q;
            es_done = m_done;
            es_ov   = m_ov;
            check_result($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
